// File: rtl/rtc_cmd_master_pkg.sv
`default_nettype none
// ============================================================================
// Module   : rtc_cmd_master_pkg
// Brief    : Opcodes, command field widths and FSM encoding for the RTC
//            command master.
// Revision : 1.0
// ============================================================================
package rtc_cmd_master_pkg;

  localparam int OP_W   = 8;
  localparam int DATA_W = 16;
  localparam int CMD_W  = OP_W + DATA_W;

  localparam logic [OP_W-1:0] RUN  = 8'd1;
  localparam logic [OP_W-1:0] STOP = 8'd2;
  localparam logic [OP_W-1:0] SET  = 8'd3;
  localparam logic [OP_W-1:0] GET  = 8'd4;
  localparam logic [OP_W-1:0] ON   = 8'd5;
  localparam logic [OP_W-1:0] OFF  = 8'd6;

  localparam int ST_W = 2;
  localparam logic [ST_W-1:0] ST_IDLE  = 2'd0;
  localparam logic [ST_W-1:0] ST_ISSUE = 2'd1;
  localparam logic [ST_W-1:0] ST_WAIT  = 2'd2;
  localparam logic [ST_W-1:0] ST_RESP  = 2'd3;

endpackage
`default_nettype wire

// File: rtl/rtc_cmd_master_cmd_fifo.sv
`default_nettype none
// ============================================================================
// Module   : cmd_fifo
// Brief    : Synchronous FIFO with head-of-queue output, no write bypass.
// Revision : 1.0
// ============================================================================
module cmd_fifo #(
  parameter int WIDTH = 24,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_wr_ptr;
  logic [PW-1:0]    r_rd_ptr;
  logic             w_push;
  logic             w_pop;

  // Extra pointer MSB distinguishes full from empty when the indices match.
  assign empty  = (r_wr_ptr == r_rd_ptr);
  assign full   = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                  (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_push = push && !full;
  assign w_pop  = pop && !empty;
  assign head   = r_mem[r_rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr[AW-1:0]] <= din;
  end

endmodule
`default_nettype wire

// File: rtl/rtc_cmd_master.sv
`default_nettype none
// ============================================================================
// Module   : rtc_cmd_master
// Brief    : Queues CPU commands and issues them to the RTC; GET ops wait
//            (bounded) for the peripheral reply and return its payload.
// Revision : 1.0
// ============================================================================
module rtc_cmd_master
  import rtc_cmd_master_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int TIMEOUT    = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [OP_W-1:0]   req_op,
  input  logic [DATA_W-1:0] req_data,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DATA_W-1:0] resp_data,
  output logic              resp_err,
  output logic              start,
  output logic [CMD_W-1:0]  cmd,
  input  logic              p_rdy,
  input  logic [CMD_W-1:0]  p_out,
  output logic              busy
);

  localparam int TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0] c_TIMER_MAX = TW'(TIMEOUT - 2);

  logic [ST_W-1:0]   r_state;
  logic [ST_W-1:0]   w_next_state;
  logic [CMD_W-1:0]  r_cmd;
  logic [TW-1:0]     r_timer;
  logic [DATA_W-1:0] r_resp_data;
  logic              r_resp_err;
  logic              w_full;
  logic              w_empty;
  logic [CMD_W-1:0]  w_head;
  logic              w_pop;
  logic              w_is_get;
  logic              w_capture;
  logic              w_timeout;

  cmd_fifo #(
    .WIDTH (CMD_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (req_valid),
    .pop   (w_pop),
    .din   ({req_op, req_data}),
    .full  (w_full),
    .empty (w_empty),
    .head  (w_head)
  );

  assign w_is_get  = (r_cmd[CMD_W-1:DATA_W] == GET);
  assign w_capture = p_rdy && ((r_state == ST_WAIT) ||
                               ((r_state == ST_ISSUE) && w_is_get));
  assign w_timeout = (r_state == ST_WAIT) && !p_rdy && (r_timer == c_TIMER_MAX);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= ST_IDLE;
    else      r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE:  if (!w_empty) w_next_state = ST_ISSUE;
      ST_ISSUE: begin
        if (!w_is_get)  w_next_state = ST_IDLE;
        else if (p_rdy) w_next_state = ST_RESP;
        else            w_next_state = ST_WAIT;
      end
      ST_WAIT:  if (p_rdy || w_timeout) w_next_state = ST_RESP;
      ST_RESP:  if (resp_ready) w_next_state = ST_IDLE;
      default:  w_next_state = ST_IDLE;
    endcase
  end

  always_comb begin
    w_pop      = 1'b0;
    start      = 1'b0;
    resp_valid = 1'b0;
    case (r_state)
      ST_IDLE:  w_pop      = !w_empty;
      ST_ISSUE: start      = 1'b1;
      ST_WAIT:  start      = 1'b1;
      ST_RESP:  resp_valid = 1'b1;
      default:  ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cmd       <= '0;
      r_timer     <= '0;
      r_resp_data <= '0;
      r_resp_err  <= 1'b0;
    end else begin
      if (w_pop) r_cmd <= w_head;

      // Timer counts WAIT cycles; it saturates so it can never wrap.
      if (r_state == ST_ISSUE)
        r_timer <= '0;
      else if ((r_state == ST_WAIT) && (r_timer != c_TIMER_MAX))
        r_timer <= r_timer + TW'(1);

      if (w_capture) begin
        r_resp_data <= p_out[DATA_W-1:0];
        r_resp_err  <= (p_out[CMD_W-1:DATA_W] != GET);
      end else if (w_timeout) begin
        r_resp_data <= '0;
        r_resp_err  <= 1'b1;
      end else if ((r_state == ST_RESP) && resp_ready) begin
        r_resp_data <= '0;
        r_resp_err  <= 1'b0;
      end
    end
  end

  assign req_ready = !w_full;
  assign cmd       = r_cmd;
  assign resp_data = r_resp_data;
  assign resp_err  = r_resp_err;
  assign busy      = (r_state != ST_IDLE) || !w_empty;

endmodule
`default_nettype wire
